// File: rtl/data4_strobe_driver_if.sv
// Capture-pair bus: word handshake in, data word plus stage-a/stage-b strobes and status out.
// The driver sits on the slave side; the upstream source or bench sits on the master side.
interface data4_strobe_driver_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             stb1;
  logic             stb2;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data,
    input  in_ready, data_out, stb1, stb2, busy, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, data_out, stb1, stb2, busy, done
  );
endinterface

// File: rtl/data4_strobe_driver.sv
// Latches a word and fires stb1 then stb2 with SETUP/PULSE/GAP timing; SETUP+2*PULSE+2*GAP cycles per word.
// Backpressure: in_ready is high only in IDLE, so a word offered while busy waits and is never dropped.
module data4_strobe_driver #(
  parameter int WIDTH = 4,
  parameter int SETUP = 2,
  parameter int PULSE = 2,
  parameter int GAP   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  data4_strobe_driver_if.slave io_bus
);

  localparam int MAXV = (SETUP > PULSE) ? ((SETUP > GAP) ? SETUP : GAP)
                                        : ((PULSE > GAP) ? PULSE : GAP);
  localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;

  localparam logic [CW-1:0] C_SETUP = CW'(SETUP - 1);
  localparam logic [CW-1:0] C_PULSE = CW'(PULSE - 1);
  localparam logic [CW-1:0] C_GAP   = CW'(GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_S1_HI,
    ST_S1_LO,
    ST_S2_HI,
    ST_S2_LO
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_stb1;
  logic             r_stb2;
  logic             r_busy;
  logic             r_done;
  logic             w_in_ready;
  logic             w_cnt_zero;

  assign w_in_ready = rst_n && (r_state == ST_IDLE);
  assign w_cnt_zero = (r_cnt == '0);

  // Strobes and status are set on the edge that enters each phase, so they track the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_data_out <= '0;
      r_stb1     <= 1'b0;
      r_stb2     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_bus.in_valid) begin
            r_data_out <= io_bus.in_data;
            r_state    <= ST_SETUP;
            r_cnt      <= C_SETUP;
            r_busy     <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (w_cnt_zero) begin
            r_state <= ST_S1_HI;
            r_cnt   <= C_PULSE;
            r_stb1  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_S1_HI: begin
          if (w_cnt_zero) begin
            r_state <= ST_S1_LO;
            r_cnt   <= C_GAP;
            r_stb1  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_S1_LO: begin
          if (w_cnt_zero) begin
            r_state <= ST_S2_HI;
            r_cnt   <= C_PULSE;
            r_stb2  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_S2_HI: begin
          if (w_cnt_zero) begin
            r_state <= ST_S2_LO;
            r_cnt   <= C_GAP;
            r_stb2  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_S2_LO: begin
          if (w_cnt_zero) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_stb1  <= 1'b0;
          r_stb2  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.in_ready = w_in_ready;
  assign io_bus.data_out = r_data_out;
  assign io_bus.stb1     = r_stb1;
  assign io_bus.stb2     = r_stb2;
  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;

endmodule

// File: tb/tb_data4_strobe_driver.sv
// Drives a default-timing driver and a minimum-timing driver with shared random traffic and
// compares every cycle against a transfer-timeline reference model.
module tb_data4_strobe_driver;

  localparam int PS[2] = '{2, 1};
  localparam int PP[2] = '{2, 1};
  localparam int PG[2] = '{2, 1};

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   cyc;

  data4_strobe_driver_if #(.WIDTH(4)) bus_a ();
  data4_strobe_driver_if #(.WIDTH(4)) bus_b ();

  data4_strobe_driver #(.WIDTH(4), .SETUP(2), .PULSE(2), .GAP(2)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus_a.slave)
  );

  data4_strobe_driver #(.WIDTH(4), .SETUP(1), .PULSE(1), .GAP(1)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: per DUT, whether a transfer was ever accepted, edges since that accept, and the word.
  logic       m_act [2];
  int         m_n   [2];
  logic [3:0] m_data[2];
  logic       tb_v;
  logic [3:0] tb_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int xfer_len(int i);
    return PS[i] + 2 * PP[i] + 2 * PG[i];
  endfunction

  function automatic logic exp_ready(int i);
    return !m_act[i] || (m_n[i] >= xfer_len(i));
  endfunction

  // Packed as {in_ready, data_out[3:0], stb1, stb2, busy, done}.
  function automatic logic [8:0] exp_out(int i);
    int   n  = m_n[i];
    logic a  = m_act[i];
    logic s1 = a && (n >= PS[i]) && (n < PS[i] + PP[i]);
    logic s2 = a && (n >= PS[i] + PP[i] + PG[i]) && (n < PS[i] + 2 * PP[i] + PG[i]);
    return {exp_ready(i), m_data[i], s1, s2, a && (n < xfer_len(i)), a && (n == xfer_len(i))};
  endfunction

  function automatic logic [8:0] obs_out(int i);
    if (i == 0)
      return {bus_a.in_ready, bus_a.data_out, bus_a.stb1, bus_a.stb2, bus_a.busy, bus_a.done};
    return {bus_b.in_ready, bus_b.data_out, bus_b.stb1, bus_b.stb2, bus_b.busy, bus_b.done};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i]  = 1'b0;
      m_n[i]    = 0;
      m_data[i] = 4'h0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i]  = 1'b0;
        m_n[i]    = 0;
        m_data[i] = 4'h0;
      end else if (tb_v && exp_ready(i)) begin
        m_act[i]  = 1'b1;
        m_n[i]    = 0;
        m_data[i] = tb_d;
      end else if (m_act[i] && m_n[i] <= xfer_len(i)) begin
        m_n[i]++;
      end
    end
  endtask

  // One cycle: check both DUTs on the falling edge, drive new inputs, let the rising edge happen.
  task automatic step(input logic v, input logic [3:0] d);
    logic [8:0] mask;
    @(negedge clk);
    mask = rst_n ? 9'h1FF : 9'h0FF;
    chk($sformatf("dutA c%0d", cyc), 32'(obs_out(0) & mask), 32'(exp_out(0) & mask));
    chk($sformatf("dutB c%0d", cyc), 32'(obs_out(1) & mask), 32'(exp_out(1) & mask));
    tb_v = v;
    tb_d = d;
    bus_a.in_valid = v;
    bus_a.in_data  = d;
    bus_b.in_valid = v;
    bus_b.in_data  = d;
    @(posedge clk);
    model_edge();
    cyc++;
  endtask

  task automatic random_steps(input int count);
    for (int k = 0; k < count; k++)
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
  endtask

  initial begin
    logic found;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 1'b0;
    tb_v  = 1'b1;
    tb_d  = 4'b1101;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 4'b1101;
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = 4'b1101;
    model_reset();

    // Reset held with in_valid asserted: everything quiet.
    repeat (4) step(1'b1, 4'b1101);
    #2 rst_n = 1'b1;
    #1;
    chk("ready_after_rst_a", 32'(bus_a.in_ready), 32'd1);
    chk("ready_after_rst_b", 32'(bus_b.in_ready), 32'd1);

    // Single word, then back-to-back with valid held high.
    step(1'b1, 4'b1101);
    repeat (30) step(1'b1, 4'b0010);
    repeat (15) step(1'b0, 4'b0000);

    random_steps(1500);

    // Reset in the middle of stb1 on the default-timing DUT.
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      step(1'b1, 4'($urandom_range(0, 15)));
      if (exp_out(0)[3]) found = 1'b1;
    end
    chk("reach_s1_hi", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_stb1_drop", 32'(bus_a.stb1), 32'd0);
    chk("async_busy_drop", 32'(bus_a.busy), 32'd0);
    chk("async_done_low",  32'(bus_a.done), 32'd0);
    chk("async_data_clr",  32'(bus_a.data_out), 32'd0);
    model_reset();
    repeat (2) step(1'b0, 4'b0000);
    #2 rst_n = 1'b1;
    #1;
    chk("ready_after_rst2", 32'(bus_a.in_ready), 32'd1);
    repeat (3) step(1'b0, 4'b0000);
    step(1'b1, 4'b0110);
    repeat (15) step(1'b0, 4'b0000);

    random_steps(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
